line_fill_unit: RTL and testbench

//  Miss-side counterpart of hit detection: on a lookup miss, picks a victim way, writes back
//  the victim line if it is dirty, fetches the missing line from memory, and installs the new
//  tag, data and valid bit into the selected way. It sits between the L2 lookup path and the

---
 rtl/line_fill_unit_pkg.sv | 19 +
 rtl/line_fill_unit_victim_select.sv | 30 +++
 rtl/line_fill_unit.sv | 160 ++++++++++++++++
 tb/tb_line_fill_unit.sv | 384 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/line_fill_unit_pkg.sv
// rtl/line_fill_unit_pkg.sv - shared cache geometry defaults and fill FSM state encoding
// Purpose: default ways/indexBits/tagBits/lineSize and the line fill state type.
// Ports: none (package).
package line_fill_unit_pkg;

    localparam int DEF_WAYS       = 8;
    localparam int DEF_INDEX_BITS = 14;
    localparam int DEF_TAG_BITS   = 10;
    localparam int DEF_LINE_SIZE  = 512;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_EVICT   = 3'd1,
        ST_FETCH   = 3'd2,
        ST_WAIT    = 3'd3,
        ST_INSTALL = 3'd4
    } fill_state_t;

endpackage

// File: rtl/line_fill_unit_victim_select.sv
// rtl/line_fill_unit_victim_select.sv - combinational victim way picker
// Purpose: choose the lowest-numbered invalid way; if the set is full, fall back to rrPtr.
// Ports:
//   i_validIn  [WAYS]         valid bits of the set
//   i_rrPtr    [log2(WAYS)]   round-robin pointer
//   o_victim   [log2(WAYS)]   selected victim way
//   o_allValid                every way of the set is valid
module line_fill_unit_victim_select #(
    parameter int WAYS = 8
) (
    input  logic [WAYS-1:0]         i_validIn,
    input  logic [$clog2(WAYS)-1:0] i_rrPtr,
    output logic [$clog2(WAYS)-1:0] o_victim,
    output logic                    o_allValid
);

    localparam int WW = $clog2(WAYS);

    always_comb begin
        o_allValid = &i_validIn;
        o_victim   = i_rrPtr;
        // Scan downward so the lowest invalid way is the last one to win.
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (!i_validIn[i]) begin
                o_victim = WW'(i);
            end
        end
    end

endmodule

// File: rtl/line_fill_unit.sv
// rtl/line_fill_unit.sv - miss handler: victim pick, dirty writeback, line fetch, install
// Purpose: services one L2 miss at a time between the lookup path and next-level memory.
// Ports:
//   clk, rst_n                           clock, asynchronous active-low reset
//   i_missValid / o_missReady            miss handshake (index, tag, set state sampled at accept)
//   i_missIndex, i_missTag               missing line address
//   i_validIn, i_dirtyIn                 per-way valid/dirty bits of the set
//   i_cacheTag, i_cacheData              per-way tags and lines of the set
//   o_memReqValid / i_memReqReady        memory request handshake
//   o_memReqWrite, o_memReqAddr,
//   o_memReqData                         request kind, {tag,index}, writeback line
//   i_memRespValid, i_memRespData        read response pulse and line
//   o_wrEn, o_wrWay, o_wrIndex,
//   o_wrTag, o_wrData, o_fillDone        array install strobe and payload
module line_fill_unit
    import line_fill_unit_pkg::*;
#(
    parameter int WAYS       = DEF_WAYS,
    parameter int INDEX_BITS = DEF_INDEX_BITS,
    parameter int TAG_BITS   = DEF_TAG_BITS,
    parameter int LINE_SIZE  = DEF_LINE_SIZE
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           i_missValid,
    output logic                           o_missReady,
    input  logic [INDEX_BITS-1:0]          i_missIndex,
    input  logic [TAG_BITS-1:0]            i_missTag,
    input  logic [WAYS-1:0]                i_validIn,
    input  logic [WAYS-1:0]                i_dirtyIn,
    input  logic [TAG_BITS*WAYS-1:0]       i_cacheTag,
    input  logic [LINE_SIZE*WAYS-1:0]      i_cacheData,
    output logic                           o_memReqValid,
    input  logic                           i_memReqReady,
    output logic                           o_memReqWrite,
    output logic [TAG_BITS+INDEX_BITS-1:0] o_memReqAddr,
    output logic [LINE_SIZE-1:0]           o_memReqData,
    input  logic                           i_memRespValid,
    input  logic [LINE_SIZE-1:0]           i_memRespData,
    output logic                           o_wrEn,
    output logic [WAYS-1:0]                o_wrWay,
    output logic [INDEX_BITS-1:0]          o_wrIndex,
    output logic [TAG_BITS-1:0]            o_wrTag,
    output logic [LINE_SIZE-1:0]           o_wrData,
    output logic                           o_fillDone
);

    localparam int WW = $clog2(WAYS);

    fill_state_t           r_state;
    logic [WW-1:0]         r_rrPtr;
    logic [WW-1:0]         r_victim;
    logic [INDEX_BITS-1:0] r_index;
    logic [TAG_BITS-1:0]   r_tag;

    logic [WW-1:0]         w_victim;
    logic                  w_allValid;
    logic                  w_accept;
    logic                  w_victimDirty;
    logic [TAG_BITS-1:0]   w_victimTag;
    logic [LINE_SIZE-1:0]  w_victimData;

    line_fill_unit_victim_select #(
        .WAYS (WAYS)
    ) u_victim_select (
        .i_validIn  (i_validIn),
        .i_rrPtr    (r_rrPtr),
        .o_victim   (w_victim),
        .o_allValid (w_allValid)
    );

    assign w_accept      = o_missReady & i_missValid;
    assign w_victimDirty = i_validIn[w_victim] & i_dirtyIn[w_victim];
    assign w_victimTag   = i_cacheTag[w_victim*TAG_BITS +: TAG_BITS];
    assign w_victimData  = i_cacheData[w_victim*LINE_SIZE +: LINE_SIZE];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_rrPtr       <= '0;
            r_victim      <= '0;
            r_index       <= '0;
            r_tag         <= '0;
            o_missReady   <= 1'b0;
            o_memReqValid <= 1'b0;
            o_memReqWrite <= 1'b0;
            o_memReqAddr  <= '0;
            o_memReqData  <= '0;
            o_wrEn        <= 1'b0;
            o_wrWay       <= '0;
            o_wrIndex     <= '0;
            o_wrTag       <= '0;
            o_wrData      <= '0;
            o_fillDone    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    o_missReady <= 1'b1;
                    if (w_accept) begin
                        o_missReady   <= 1'b0;
                        r_index       <= i_missIndex;
                        r_tag         <= i_missTag;
                        r_victim      <= w_victim;
                        if (w_allValid) begin
                            r_rrPtr <= r_rrPtr + WW'(1);
                        end
                        // The first request is launched at accept so it is visible
                        // in the very next cycle; the victim tag/line are captured
                        // directly into the request payload registers.
                        o_memReqValid <= 1'b1;
                        if (w_victimDirty) begin
                            r_state       <= ST_EVICT;
                            o_memReqWrite <= 1'b1;
                            o_memReqAddr  <= {w_victimTag, i_missIndex};
                            o_memReqData  <= w_victimData;
                        end else begin
                            r_state       <= ST_FETCH;
                            o_memReqWrite <= 1'b0;
                            o_memReqAddr  <= {i_missTag, i_missIndex};
                        end
                    end
                end
                ST_EVICT: begin
                    if (i_memReqReady) begin
                        r_state       <= ST_FETCH;
                        o_memReqWrite <= 1'b0;
                        o_memReqAddr  <= {r_tag, r_index};
                    end
                end
                ST_FETCH: begin
                    if (i_memReqReady) begin
                        r_state       <= ST_WAIT;
                        o_memReqValid <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    if (i_memRespValid) begin
                        r_state    <= ST_INSTALL;
                        o_wrEn     <= 1'b1;
                        o_fillDone <= 1'b1;
                        o_wrWay    <= WAYS'(1) << r_victim;
                        o_wrIndex  <= r_index;
                        o_wrTag    <= r_tag;
                        o_wrData   <= i_memRespData;
                    end
                end
                ST_INSTALL: begin
                    r_state     <= ST_IDLE;
                    o_wrEn      <= 1'b0;
                    o_fillDone  <= 1'b0;
                    o_missReady <= 1'b1;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_line_fill_unit.sv
// tb/tb_line_fill_unit.sv - scoreboard bench for line_fill_unit
module tb_line_fill_unit;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           i_missValid;
    logic           o_missReady;
    logic [13:0]    i_missIndex;
    logic [9:0]     i_missTag;
    logic [7:0]     i_validIn;
    logic [7:0]     i_dirtyIn;
    logic [79:0]    i_cacheTag;
    logic [4095:0]  i_cacheData;
    logic           o_memReqValid;
    logic           i_memReqReady;
    logic           o_memReqWrite;
    logic [23:0]    o_memReqAddr;
    logic [511:0]   o_memReqData;
    logic           i_memRespValid;
    logic [511:0]   i_memRespData;
    logic           o_wrEn;
    logic [7:0]     o_wrWay;
    logic [13:0]    o_wrIndex;
    logic [9:0]     o_wrTag;
    logic [511:0]   o_wrData;
    logic           o_fillDone;

    line_fill_unit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_missValid    (i_missValid),
        .o_missReady    (o_missReady),
        .i_missIndex    (i_missIndex),
        .i_missTag      (i_missTag),
        .i_validIn      (i_validIn),
        .i_dirtyIn      (i_dirtyIn),
        .i_cacheTag     (i_cacheTag),
        .i_cacheData    (i_cacheData),
        .o_memReqValid  (o_memReqValid),
        .i_memReqReady  (i_memReqReady),
        .o_memReqWrite  (o_memReqWrite),
        .o_memReqAddr   (o_memReqAddr),
        .o_memReqData   (o_memReqData),
        .i_memRespValid (i_memRespValid),
        .i_memRespData  (i_memRespData),
        .o_wrEn         (o_wrEn),
        .o_wrWay        (o_wrWay),
        .o_wrIndex      (o_wrIndex),
        .o_wrTag        (o_wrTag),
        .o_wrData       (o_wrData),
        .o_fillDone     (o_fillDone)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit           wr;
        logic [23:0]  addr;
        logic [511:0] data;
    } req_t;

    typedef struct {
        logic [7:0]   way;
        logic [13:0]  idx;
        logic [9:0]   tag;
        logic [511:0] data;
    } ins_t;

    req_t exp_req_q[$];
    ins_t exp_ins_q[$];
    ins_t pend_q[$];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int fetch_hs = 0;
    int served = 0;
    int stray_req = 0;
    int stray_done = 0;
    int last_wr_cyc = -100;
    int m_rr = 0;
    bit auto_resp = 1'b1;
    bit hold_low = 1'b0;

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [511:0] rand_line();
        logic [511:0] l;
        for (int k = 0; k < 16; k++) l[k*32 +: 32] = $urandom;
        return l;
    endfunction

    task automatic rand_set();
        for (int w = 0; w < 8; w++) begin
            i_cacheTag[w*10 +: 10]   = 10'($urandom);
            i_cacheData[w*512 +: 512] = rand_line();
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Ready driver: random unless a test asks for backpressure.
    initial forever begin
        @(posedge clk); #1;
        i_memReqReady = hold_low ? 1'b0 : ($urandom_range(0, 3) != 0);
    end

    // Memory responder: answers each fetch handshake after a random delay.
    initial begin
        int   wl;
        ins_t e;
        logic [511:0] line;
        wl = -1;
        forever begin
            @(posedge clk); #1;
            i_memRespValid = 1'b0;
            if (!auto_resp) begin
                served = fetch_hs;
                wl = -1;
            end
            if (stray_req != stray_done) begin
                i_memRespValid = 1'b1;
                i_memRespData  = rand_line();
                stray_done++;
            end else if (fetch_hs != served) begin
                if (wl < 0) wl = $urandom_range(0, 3);
                if (wl == 0) begin
                    line = rand_line();
                    if (pend_q.size() > 0) begin
                        e = pend_q.pop_front();
                        e.data = line;
                        exp_ins_q.push_back(e);
                    end
                    i_memRespValid = 1'b1;
                    i_memRespData  = line;
                    served++;
                    wl = -1;
                end else begin
                    wl--;
                end
            end
        end
    end

    // Monitor: pops expectations whenever the DUT presents a request or an install.
    initial begin
        req_t r;
        ins_t e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (o_memReqValid && i_memReqReady) begin
                    if (exp_req_q.size() == 0) begin
                        chk("unexpected_req", {o_memReqWrite, o_memReqAddr}, 0);
                    end else begin
                        r = exp_req_q.pop_front();
                        chk("req_write", o_memReqWrite, r.wr);
                        chk("req_addr", o_memReqAddr, r.addr);
                        if (r.wr) chk("req_wb_data", o_memReqData, r.data);
                    end
                    if (!o_memReqWrite) fetch_hs++;
                end
                if (o_wrEn) begin
                    last_wr_cyc = cyc;
                    if (exp_ins_q.size() == 0) begin
                        chk("unexpected_wren", o_wrWay, 0);
                    end else begin
                        e = exp_ins_q.pop_front();
                        chk("wr_way", o_wrWay, e.way);
                        chk("wr_index", o_wrIndex, e.idx);
                        chk("wr_tag", o_wrTag, e.tag);
                        chk("wr_data", o_wrData, e.data);
                        chk("fill_done", o_fillDone, 1'b1);
                    end
                end else if (o_fillDone) begin
                    chk("stray_fill_done", o_fillDone, 1'b0);
                end
            end
        end
    end

    task automatic do_miss(input logic [7:0] v, input logic [7:0] d, input logic [9:0] tag,
                           input logic [13:0] idx, input bit hold, output int acc);
        int   vic;
        bit   ok;
        req_t r;
        ins_t p;
        vic = -1;
        for (int k = 0; k < 8; k++) if (vic < 0 && !v[k]) vic = k;
        if (vic < 0) begin
            vic  = m_rr;
            m_rr = (m_rr + 1) % 8;
        end
        if (v[vic] && d[vic]) begin
            r.wr   = 1'b1;
            r.addr = {i_cacheTag[vic*10 +: 10], idx};
            r.data = i_cacheData[vic*512 +: 512];
            exp_req_q.push_back(r);
        end
        r.wr   = 1'b0;
        r.addr = {tag, idx};
        r.data = '0;
        exp_req_q.push_back(r);
        p.way  = 8'(1 << vic);
        p.idx  = idx;
        p.tag  = tag;
        p.data = '0;
        pend_q.push_back(p);
        i_validIn   = v;
        i_dirtyIn   = d;
        i_missTag   = tag;
        i_missIndex = idx;
        i_missValid = 1'b1;
        ok  = 1'b0;
        acc = -1;
        for (int c = 0; c < 400 && !ok; c++) begin
            @(negedge clk);
            if (o_missReady) begin
                ok  = 1'b1;
                acc = cyc + 1;
            end
        end
        chk("accept_timeout", ok, 1'b1);
        @(posedge clk); #1;
        if (!hold) i_missValid = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < 500 && !ok; c++) begin
            @(negedge clk);
            if (o_missReady && exp_req_q.size() == 0 && exp_ins_q.size() == 0 && pend_q.size() == 0)
                ok = 1'b1;
        end
        chk("idle_timeout", ok, 1'b1);
        @(posedge clk); #1;
    endtask

    task automatic chk_reset_outputs();
        chk("rst_ctrl", {o_missReady, o_memReqValid, o_memReqWrite, o_memReqAddr, o_wrEn,
                         o_fillDone, o_wrWay, o_wrIndex, o_wrTag}, 0);
        chk("rst_data", o_memReqData | o_wrData, 0);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        i_missValid = 1'b0;
        exp_req_q.delete();
        exp_ins_q.delete();
        pend_q.delete();
        m_rr = 0;
        @(negedge clk);
        chk_reset_outputs();
        rst_n = 1'b1;
        #1;
        chk("ready_before_edge", o_missReady, 1'b0);
        @(negedge clk);
        chk("ready_after_release", o_missReady, 1'b1);
        @(posedge clk); #1;
    endtask

    initial begin
        int a1, a2, hs0, cnt;
        bit ok;
        logic [9:0]  t;
        logic [13:0] ix;
        rst_n = 1'b0;
        i_missValid = 1'b0;
        i_missIndex = '0;
        i_missTag = '0;
        i_validIn = '0;
        i_dirtyIn = '0;
        i_cacheTag = '0;
        i_cacheData = '0;
        i_memReqReady = 1'b0;
        i_memRespValid = 1'b0;
        i_memRespData = '0;
        repeat (2) @(posedge clk);
        #1;
        apply_reset();

        // 1 clean miss into an empty set
        rand_set();
        do_miss(8'h00, 8'h00, 10'h155, 14'h0A3, 1'b0, a1);
        wait_idle();

        // 2 dirty victim in a full set, rrPtr at 0
        rand_set();
        i_cacheTag[9:0] = 10'h2AA;
        do_miss(8'hFF, 8'h01, 10'h0F0, 14'h1234, 1'b0, a1);
        wait_idle();

        // 3 round-robin over a full clean set
        apply_reset();
        for (int n = 0; n < 9; n++) begin
            rand_set();
            do_miss(8'hFF, 8'h00, 10'($urandom), 14'($urandom), 1'b0, a1);
            wait_idle();
        end

        // 4 backpressure in FETCH plus a stray response
        hold_low = 1'b1;
        @(posedge clk); #1;
        hs0 = fetch_hs;
        rand_set();
        do_miss(8'h0F, 8'h00, 10'h3C3, 14'h2A5A, 1'b0, a1);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("bp_valid", o_memReqValid, 1'b1);
            chk("bp_addr", o_memReqAddr, {10'h3C3, 14'h2A5A});
            if (c == 1) stray_req++;
        end
        hold_low = 1'b0;
        wait_idle();
        chk("bp_handshakes", fetch_hs - hs0, 1);

        // 5 reset while waiting for the response
        auto_resp = 1'b0;
        rand_set();
        do_miss(8'h00, 8'h00, 10'h111, 14'h0222, 1'b0, a1);
        ok = 1'b0;
        for (int c = 0; c < 200 && !ok; c++) begin
            @(negedge clk);
            if (fetch_hs != hs0 + 1) ok = 1'b1;
        end
        chk("wait_fetch_timeout", ok, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        exp_req_q.delete();
        exp_ins_q.delete();
        pend_q.delete();
        m_rr = 0;
        @(negedge clk);
        chk_reset_outputs();
        @(negedge clk);
        chk_reset_outputs();
        rst_n = 1'b1;
        stray_req++;
        #1;
        chk("ready_before_edge2", o_missReady, 1'b0);
        @(negedge clk);
        chk("ready_after_release2", o_missReady, 1'b1);
        cnt = last_wr_cyc;
        repeat (4) @(negedge clk);
        chk("no_install_after_reset", last_wr_cyc, cnt);
        @(posedge clk); #1;
        auto_resp = 1'b1;
        @(posedge clk); #1;

        // 6 back-to-back misses with missValid held high
        rand_set();
        do_miss(8'h00, 8'h00, 10'h01A, 14'h0033, 1'b1, a1);
        rand_set();
        do_miss(8'h03, 8'h00, 10'h2B2, 14'h0044, 1'b0, a2);
        chk("b2b_accept_cycle", a2, last_wr_cyc + 2);
        wait_idle();

        // random misses
        for (int n = 0; n < 40; n++) begin
            rand_set();
            t  = 10'($urandom);
            ix = 14'($urandom);
            do_miss(($urandom_range(0, 1) != 0) ? 8'hFF : 8'($urandom), 8'($urandom), t, ix, 1'b0, a1);
            wait_idle();
        end

        chk("req_queue_empty", exp_req_q.size(), 0);
        chk("ins_queue_empty", exp_ins_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
